csr_uart_tx: RTL and testbench
==============================

# csr_uart_tx

CSR-mapped UART transmitter on the core's CSR peripheral bus, downstream of the pipeline's CSR port beside the counter, pin and timer peripherals. A write to the UART data CSR enqueues a byte into a small FIFO. An 8N1 serializer drains the FIFO onto `tx` at a fixed baud rate. Status reads let software poll for FIFO space and transmitter idle, replacing the simulation-only console with synthesizable hardware.

## Interface
- `BASE_ADDR`, 12'hbc0: CSR address of the data/status register.
- `CLOCK_RATE`, 100_000_000: clk frequency in Hz.
- `BAUD_RATE`, 115_200: line rate; `DIVISOR = CLOCK_RATE / BAUD_RATE` (integer, ≥ 2), in clk cycles per bit.
- `FIFO_LOG2`, 4: FIFO depth is 2**FIFO_LOG2 bytes.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `read`  in  1  address-phase read strobe.
- `modify`  in  3  data-phase modify code: 0 none, 1 write, 2 set, 3 clear.
- `wdata`  in  32  data-phase write data.
- `addr`  in  12  address-phase CSR address.
- `rdata`  out  32  read data; 0 when not selected (OR-combined bus).
- `valid`  out  1  this block claims the access.
- `tx`  out  1  serial line, idle high.

## Operation
- **CSR protocol**
  - Address phase in cycle N: `addr`, `read`.
  - Data phase in cycle N+1: `modify`, `wdata`.
  - The block registers `addr==BASE_ADDR` at the N edge as `sel`.
  - In cycle N+1, `valid = sel & (read_q | modify!=0)` and `rdata = sel & read_q ? status : 0`. Here `read_q` is `read` registered at the N edge.
- **Status word**
  - bit0 `full`: FIFO count == depth.
  - bit1 `idle`: FIFO empty and serializer in IDLE.
  - bit2 `overflow`: sticky flag.
  - All other bits 0.
- **Enqueue:** `sel & modify==1` pushes `wdata[7:0]`. Modify codes 2 and 3 are claimed (`valid`=1) but have no effect.
- **Full FIFO:** a push while full is dropped and sets `overflow`. Fullness is sampled before any same-cycle pop, so a simultaneous pop does not rescue the push.
- **Overflow clear:** a read of the register returns the current `overflow` and clears it at the end of that data phase. If a dropped push occurs in the same cycle, the set wins.
- **FIFO:** read/write pointers are FIFO_LOG2 bits and wrap modulo depth. The count is FIFO_LOG2+1 bits.
- **Serializer FSM:** IDLE → START → DATA → STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for DIVISOR cycles.
  - DATA: 8 bits, LSB first, each held DIVISOR cycles, with a 3-bit bit index.
  - STOP: `tx`=1 for DIVISOR cycles. If the FIFO is non-empty at the last stop cycle, pop and go directly to START (back-to-back frames, no extra idle). Otherwise go to IDLE.
- **Baud counter:** counts DIVISOR-1 down to 0 and reloads on every bit boundary. Width is `$clog2(DIVISOR)`.

## Timing
- **Reset values:** `tx`=1, `rdata`=0, `valid`=0, FIFO empty, `overflow`=0, FSM IDLE, `sel`/`read_q`=0.
- **Reset mid-frame:** `tx` returns to 1 asynchronously, the frame is abandoned and FIFO contents are discarded.
- **Read latency:** status is valid in the cycle after the address phase (data phase).
- **Push to head:** a push at the N+1 edge makes the byte the FIFO head in cycle N+2.
- **Idle to start bit:** with the serializer idle, the IDLE pop occurs at the N+2 edge. `tx` goes low (registered) from cycle N+3.
- **Frame length:** exactly 10×DIVISOR cycles. Back-to-back frames have no gap.
- **`idle` bit:** reads 0 from the cycle after a push until the final stop-bit cycle completes with the FIFO empty.
- **`tx` output:** driven directly from a flop, glitch-free.

## Structure
- **Shared package `csr_pkg`:**
  - modify codes (`MOD_NONE`, `MOD_WRITE`, `MOD_SET`, `MOD_CLEAR`);
  - status bit indices (`UART_FULL`, `UART_IDLE`, `UART_OVF`);
  - CSR address constants (`CSR_UART` 12'hbc0, `CSR_TIMER` 12'hbc2, `CSR_SIM` 12'h3ff);
  - serializer state enum.
- **Sub-module `csr_uart_fifo`:** synchronous FIFO, parameterized by `FIFO_LOG2` with width 8. Ports: push/pop/din/dout/full/empty.
- **Top level:** contains the CSR decode, status logic, baud counter and FSM.

## Test plan
- **Single byte:** DIVISOR=10; write 8'h41 at t0 → `tx` low from t0+2 for 10 cycles, then bits 1,0,0,0,0,0,1,0 at 10 cycles each, then high for 10; `idle` reads 1 afterwards.
- **Back-to-back:** write 8'h55 and 8'hAA in consecutive transactions → 200 contiguous cycles of framing with no idle cycles between the stop bit of frame 1 and the start bit of frame 2.
- **Overflow:** FIFO_LOG2=2; write 6 bytes while the first frame is in flight → `full`=1. The 6th write is dropped and `overflow`=1 on the next read, then 0 on the read after. Exactly 5 frames are emitted.
- **Bus decode:** read `addr`=12'hbc2 → `valid`=0, `rdata`=0. Read `addr`=12'hbc0 after reset → `valid`=1, `rdata`=32'h2. `modify`=2 at 12'hbc0 → `valid`=1, FIFO unchanged.
- **Reset mid-frame:** assert `rst` during data bit 3 of 8'hFF with 2 bytes queued → `tx`=1 asynchronously. After release, `idle`=1, no further frames, and a new write transmits normally.
- **Pop/push race:** with the FIFO full, push in the same cycle as a pop → push dropped, `overflow`=1, FIFO count = depth-1.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR peripheral bus: modify codes, CSR addresses,
// UART status bit positions and the UART serializer state encoding.
package csr_pkg;

   localparam logic [2:0] MOD_NONE  = 3'd0;
   localparam logic [2:0] MOD_WRITE = 3'd1;
   localparam logic [2:0] MOD_SET   = 3'd2;
   localparam logic [2:0] MOD_CLEAR = 3'd3;

   localparam int UART_FULL = 0;
   localparam int UART_IDLE = 1;
   localparam int UART_OVF  = 2;

   localparam logic [11:0] CSR_UART  = 12'hbc0;
   localparam logic [11:0] CSR_TIMER = 12'hbc2;
   localparam logic [11:0] CSR_SIM   = 12'h3ff;

   typedef enum logic [1:0] {
      UART_S_IDLE,
      UART_S_START,
      UART_S_DATA,
      UART_S_STOP
   } uart_state_e;

endpackage

// File: rtl/csr_uart_fifo.sv
// Byte-wide synchronous FIFO feeding the UART serializer; pushes while full and
// pops while empty are ignored.
module csr_uart_fifo
   import csr_pkg::*;
#(
   parameter int FIFO_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int DEPTH = 2 ** FIFO_LOG2;

   logic [7:0]           mem_q [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_LOG2:0]   count_q, count_d;
   logic                 push_ok;
   logic                 pop_ok;

   assign full    = (count_q == (FIFO_LOG2 + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/csr_uart_tx.sv
// CSR-mapped 8N1 UART transmitter: data-phase writes enqueue bytes, reads return
// full/idle/overflow status, and a baud-timed serializer drains the FIFO onto tx.
module csr_uart_tx
   import csr_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR  = CSR_UART,
   parameter int          CLOCK_RATE = 100_000_000,
   parameter int          BAUD_RATE  = 115_200,
   parameter int          FIFO_LOG2  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic [2:0]  modify,
   input  logic [31:0] wdata,
   input  logic [11:0] addr,
   output logic [31:0] rdata,
   output logic        valid,
   output logic        tx
);

   localparam int              DIVISOR     = CLOCK_RATE / BAUD_RATE;
   localparam int              BAUD_W      = $clog2(DIVISOR);
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(DIVISOR - 1);

   logic        sel_q, sel_d;
   logic        read_q, read_d;
   logic        overflow_q, overflow_d;
   uart_state_e state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;

   logic        push_req;
   logic        status_rd;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_dout;
   logic [31:0] status;
   logic        baud_done;
   logic        unused_wdata_bits;

   assign unused_wdata_bits = ^wdata[31:8];

   csr_uart_fifo #(
      .FIFO_LOG2 (FIFO_LOG2)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req & ~fifo_full),
      .pop   (fifo_pop),
      .din   (wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A dropped push outranks the read-side clear of the sticky overflow flag.
   always_comb begin
      sel_d      = (addr == BASE_ADDR);
      read_d     = read;
      status_rd  = sel_q & read_q;
      push_req   = sel_q & (modify == MOD_WRITE);
      overflow_d = overflow_q;
      if (status_rd) begin
         overflow_d = 1'b0;
      end
      if (push_req & fifo_full) begin
         overflow_d = 1'b1;
      end
      status            = '0;
      status[UART_FULL] = fifo_full;
      status[UART_IDLE] = fifo_empty & (state_q == UART_S_IDLE);
      status[UART_OVF]  = overflow_q;
      valid = sel_q & (read_q | (modify != MOD_NONE));
      rdata = status_rd ? status : '0;
   end

   assign baud_done = (baud_q == '0);

   // tx_d is the line level for the next cycle, so each bit appears on the
   // registered output exactly when its state begins.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      fifo_pop  = 1'b0;
      case (state_q)
         UART_S_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               baud_d   = BAUD_RELOAD;
               tx_d     = 1'b0;
               state_d  = UART_S_START;
            end
         end
         UART_S_START: begin
            if (baud_done) begin
               baud_d    = BAUD_RELOAD;
               bit_idx_d = 3'd0;
               tx_d      = shift_q[0];
               state_d   = UART_S_DATA;
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         UART_S_DATA: begin
            if (baud_done) begin
               baud_d = BAUD_RELOAD;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = UART_S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         UART_S_STOP: begin
            if (baud_done) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  baud_d   = BAUD_RELOAD;
                  tx_d     = 1'b0;
                  state_d  = UART_S_START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = UART_S_IDLE;
               end
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = UART_S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q      <= 1'b0;
         read_q     <= 1'b0;
         overflow_q <= 1'b0;
         state_q    <= UART_S_IDLE;
         baud_q     <= BAUD_RELOAD;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'd0;
         tx_q       <= 1'b1;
      end else begin
         sel_q      <= sel_d;
         read_q     <= read_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
      end
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_csr_uart_tx.sv
// Bench for csr_uart_tx at DIVISOR=10 and a 4-entry FIFO: a frame-level model
// checks tx/valid/rdata every cycle, and a line decoder pins it with literals.
module tb_csr_uart_tx;

   localparam int D     = 10;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * D;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read = 1'b0;
   logic [2:0]  modify = 3'd0;
   logic [31:0] wdata = 32'd0;
   logic [11:0] addr = 12'd0;
   logic [31:0] rdata;
   logic        valid;
   logic        tx;

   csr_uart_tx #(
      .BASE_ADDR  (12'hbc0),
      .CLOCK_RATE (100),
      .BAUD_RATE  (10),
      .FIFO_LOG2  (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .read   (read),
      .modify (modify),
      .wdata  (wdata),
      .addr   (addr),
      .rdata  (rdata),
      .valid  (valid),
      .tx     (tx)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc_count = 0;

   always @(posedge clk) cyc_count++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_count, act, req);
      end
   endtask

   // Frame-level model: queued bytes plus position within the frame on the line.
   logic [7:0] m_fifo[$];
   int         m_cyc = -1;
   logic [7:0] m_byte = 8'd0;
   logic       m_sel = 1'b0;
   logic       m_readq = 1'b0;
   logic       m_ovf = 1'b0;

   // Independent line decoder sampling the DUT tx mid-bit.
   int         rx_cnt = -1;
   logic [7:0] rx_shift = 8'd0;
   logic [7:0] rx_bytes[$];
   int         rx_starts[$];

   function automatic logic modelTx(input int pos, input logic [7:0] b);
      int k;
      if (pos < 0) return 1'b1;
      k = pos / D;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   always @(negedge clk) begin
      logic [31:0] status_m;
      logic        push;
      logic        full_now;
      int          k;
      if (rst) begin
         m_fifo.delete();
         m_cyc   = -1;
         m_sel   = 1'b0;
         m_readq = 1'b0;
         m_ovf   = 1'b0;
         rx_cnt  = -1;
         checkOutput("reset_tx", {31'd0, tx}, 32'd1);
         checkOutput("reset_valid", {31'd0, valid}, 32'd0);
         checkOutput("reset_rdata", rdata, 32'd0);
      end else begin
         status_m    = 32'd0;
         status_m[0] = (m_fifo.size() == DEPTH);
         status_m[1] = (m_fifo.size() == 0) && (m_cyc < 0);
         status_m[2] = m_ovf;
         checkOutput("tx", {31'd0, tx}, {31'd0, modelTx(m_cyc, m_byte)});
         checkOutput("valid", {31'd0, valid}, {31'd0, m_sel && (m_readq || modify != 3'd0)});
         checkOutput("rdata", rdata, (m_sel && m_readq) ? status_m : 32'd0);

         if (rx_cnt < 0 && tx == 1'b0) begin
            rx_cnt = 0;
            rx_starts.push_back(cyc_count);
         end
         if (rx_cnt >= 0) begin
            if (rx_cnt % D == D / 2) begin
               k = rx_cnt / D;
               if (k >= 1 && k <= 8) rx_shift[k-1] = tx;
            end
            if (rx_cnt == 9 * D + D / 2) begin
               checkOutput("rx_stop", {31'd0, tx}, 32'd1);
               rx_bytes.push_back(rx_shift);
               rx_cnt = -1;
            end else begin
               rx_cnt++;
            end
         end

         push     = m_sel && (modify == 3'd1);
         full_now = (m_fifo.size() == DEPTH);
         if (m_cyc < 0) begin
            if (m_fifo.size() > 0) begin
               m_byte = m_fifo.pop_front();
               m_cyc  = 0;
            end
         end else if (m_cyc == FRAME - 1) begin
            if (m_fifo.size() > 0) begin
               m_byte = m_fifo.pop_front();
               m_cyc  = 0;
            end else begin
               m_cyc = -1;
            end
         end else begin
            m_cyc++;
         end
         if (push && !full_now) m_fifo.push_back(wdata[7:0]);
         if (m_sel && m_readq) m_ovf = 1'b0;
         if (push && full_now) m_ovf = 1'b1;
         m_sel   = (addr == 12'hbc0);
         m_readq = read;
      end
   end

   // One address phase followed by one data phase; returns data-phase rdata/valid.
   task automatic applyStimulus(input logic [11:0] a, input logic rd, input logic [2:0] mod,
                                input logic [7:0] data, output logic [31:0] rd_val, output logic vld);
      @(posedge clk); #1;
      addr = a; read = rd; modify = 3'd0;
      @(posedge clk); #1;
      addr = 12'd0; read = 1'b0; modify = mod; wdata = {24'hdeadbe, data};
      @(negedge clk);
      rd_val = rdata;
      vld    = valid;
      @(posedge clk); #1;
      modify = 3'd0; wdata = 32'd0;
   endtask

   task automatic writeByte(input logic [7:0] data);
      logic [31:0] v;
      logic        vl;
      applyStimulus(12'hbc0, 1'b0, 3'd1, data, v, vl);
   endtask

   task automatic readStatus(output logic [31:0] v);
      logic vl;
      applyStimulus(12'hbc0, 1'b1, 3'd0, 8'd0, v, vl);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitTxLow(output int s);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (tx == 1'b0) break;
      end
      s = cyc_count;
      checkOutput("tx_start_seen", {31'd0, tx}, 32'd0);
   endtask

   initial begin
      logic [31:0] v;
      logic        vl;
      logic [9:0]  pat;
      int          s;
      int          base;

      waitCycles(3);
      rst = 1'b0;

      // Bus decode
      applyStimulus(12'hbc2, 1'b1, 3'd0, 8'd0, v, vl);
      checkOutput("decode_other_valid", {31'd0, vl}, 32'd0);
      checkOutput("decode_other_rdata", v, 32'd0);
      applyStimulus(12'hbc0, 1'b1, 3'd0, 8'd0, v, vl);
      checkOutput("decode_own_valid", {31'd0, vl}, 32'd1);
      checkOutput("reset_status", v, 32'h2);
      applyStimulus(12'hbc0, 1'b0, 3'd2, 8'h77, v, vl);
      checkOutput("set_valid", {31'd0, vl}, 32'd1);
      readStatus(v);
      checkOutput("set_status", v, 32'h2);
      waitCycles(5);
      checkOutput("set_no_frame", rx_starts.size(), 32'd0);

      // Single byte
      writeByte(8'h41);
      checkOutput("start_pre", {31'd0, tx}, 32'd1);
      waitCycles(1);
      checkOutput("start_low", {31'd0, tx}, 32'd0);
      pat = {1'b1, 8'h41, 1'b0};
      waitCycles(5);
      for (int k = 0; k < 10; k++) begin
         checkOutput($sformatf("frame41_bit%0d", k), {31'd0, tx}, {31'd0, pat[k]});
         waitCycles(D);
      end
      readStatus(v);
      checkOutput("idle_after_41", v, 32'h2);
      checkOutput("rx_count_41", rx_bytes.size(), 32'd1);
      checkOutput("rx_byte_41", {24'd0, rx_bytes[0]}, 32'h41);

      // Back-to-back
      writeByte(8'h55);
      writeByte(8'hAA);
      waitCycles(220);
      checkOutput("rx_count_b2b", rx_bytes.size(), 32'd3);
      checkOutput("rx_byte_55", {24'd0, rx_bytes[1]}, 32'h55);
      checkOutput("rx_byte_aa", {24'd0, rx_bytes[2]}, 32'haa);
      checkOutput("b2b_gap", rx_starts[2] - rx_starts[1], FRAME);

      // Overflow
      base = rx_bytes.size();
      for (int i = 0; i < 6; i++) writeByte(8'hC1 + 8'(i));
      readStatus(v);
      checkOutput("ovf_status_first", v, 32'h5);
      readStatus(v);
      checkOutput("ovf_status_second", v, 32'h1);
      waitCycles(6 * FRAME);
      checkOutput("ovf_frames", rx_bytes.size() - base, 32'd5);
      for (int i = 0; i < 5; i++)
         checkOutput($sformatf("ovf_byte%0d", i), {24'd0, rx_bytes[base+i]}, 32'hC1 + i);
      readStatus(v);
      checkOutput("ovf_drained_status", v, 32'h2);

      // Pop/push race on the last stop cycle
      base = rx_bytes.size();
      writeByte(8'h11);
      waitTxLow(s);
      writeByte(8'h22);
      writeByte(8'h33);
      writeByte(8'h44);
      writeByte(8'h55);
      while (cyc_count < s + 97) begin
         @(posedge clk); #1;
      end
      writeByte(8'h66);
      readStatus(v);
      checkOutput("race_status", v, 32'h4);
      waitCycles(5 * FRAME);
      checkOutput("race_frames", rx_bytes.size() - base, 32'd5);
      checkOutput("race_last_byte", {24'd0, rx_bytes[rx_bytes.size()-1]}, 32'h55);
      readStatus(v);
      checkOutput("race_final_status", v, 32'h2);

      // Reset during data bit 3 of 0xFF with two bytes queued
      writeByte(8'hFF);
      waitTxLow(s);
      writeByte(8'h12);
      writeByte(8'h34);
      while (cyc_count < s + 45) begin
         @(posedge clk); #1;
      end
      base = rx_bytes.size();
      #2 rst = 1'b1;
      #1 checkOutput("async_reset_tx_data", {31'd0, tx}, 32'd1);
      waitCycles(2);
      rst = 1'b0;
      readStatus(v);
      checkOutput("post_reset_status", v, 32'h2);
      waitCycles(2 * FRAME);
      checkOutput("post_reset_no_frames", rx_bytes.size() - base, 32'd0);
      writeByte(8'h5A);
      waitCycles(FRAME + 20);
      checkOutput("post_reset_frames", rx_bytes.size() - base, 32'd1);
      checkOutput("post_reset_byte", {24'd0, rx_bytes[rx_bytes.size()-1]}, 32'h5a);

      // Reset while the start bit is on the line
      writeByte(8'h00);
      waitTxLow(s);
      waitCycles(3);
      #2 rst = 1'b1;
      #1 checkOutput("async_reset_tx_start", {31'd0, tx}, 32'd1);
      waitCycles(2);
      rst = 1'b0;
      readStatus(v);
      checkOutput("post_reset2_status", v, 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
